// File: rtl/onehot_encoder_8to3_if.sv
// Bus between an 8-line one-hot source and the onehot_encoder_8to3 receiver.
// The master drives the input lines; the slave (the encoder) drives the status and code outputs.
interface onehot_encoder_8to3_if #(
    parameter int WRAP_W = 4
);
    logic [7:0]        signal_i;
    logic [2:0]        signal_o;
    logic              valid;
    logic              multi_hot;
    logic              step;
    logic              seq_error;
    logic [WRAP_W-1:0] wrap_count;

    modport master (
        output signal_i,
        input  signal_o, valid, multi_hot, step, seq_error, wrap_count
    );

    modport slave (
        input  signal_i,
        output signal_o, valid, multi_hot, step, seq_error, wrap_count
    );
endinterface

// File: rtl/onehot_encoder_8to3.sv
// Registered 8-to-3 encoder with a stability filter and optional modulo-8 sequence checking.
// Define ENCODER_SEQCHECK_EN to build the sequence FSM, seq_error and wrap_count; otherwise those outputs are tied to 0.
module onehot_encoder_8to3 #(
    parameter int STABLE_CYCLES = 3,
    parameter int WRAP_W        = 4
) (
    input  logic                  clockpulse,
    input  logic                  clear,
    onehot_encoder_8to3_if.slave  bus
);
    localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);

    logic [7:0] cand;
    logic [7:0] acc;
    logic [3:0] cnt;
    logic [3:0] cnt_next;
    logic       accept;
    logic       valid_accept;
    logic [2:0] code_next;
    logic       multi_next;

    logic [2:0] code_q;
    logic       valid_q;
    logic       multi_q;
    logic       step_q;

    // Acceptance is judged on the post-edge filter state, so STABLE_CYCLES=1 accepts on the first sample.
    always_comb begin
        if (bus.signal_i != cand) begin
            cnt_next = 4'd1;
        end else if (cnt >= STABLE) begin
            cnt_next = STABLE;
        end else begin
            cnt_next = cnt + 4'd1;
        end
        accept       = (cnt_next == STABLE) && (bus.signal_i != acc);
        valid_accept = accept && (bus.signal_i != 8'd0);
        code_next    = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (bus.signal_i[i]) begin
                code_next = 3'(i);
            end
        end
        multi_next = ($countones(bus.signal_i) > 1);
    end

    always_ff @(posedge clockpulse) begin
        if (clear) begin
            cand    <= 8'd0;
            cnt     <= 4'd0;
            acc     <= 8'd0;
            code_q  <= 3'd0;
            valid_q <= 1'b0;
            multi_q <= 1'b0;
            step_q  <= 1'b0;
        end else begin
            cand   <= bus.signal_i;
            cnt    <= cnt_next;
            step_q <= 1'b0;
            if (accept) begin
                acc <= bus.signal_i;
                if (valid_accept) begin
                    valid_q <= 1'b1;
                    multi_q <= multi_next;
                    code_q  <= code_next;
                    step_q  <= 1'b1;
                end else begin
                    valid_q <= 1'b0;
                    multi_q <= 1'b0;
                end
            end
        end
    end

    assign bus.signal_o  = code_q;
    assign bus.valid     = valid_q;
    assign bus.multi_hot = multi_q;
    assign bus.step      = step_q;

`ifdef ENCODER_SEQCHECK_EN
    typedef enum logic {
        EMPTY,
        LOCKED
    } seq_state_t;

    seq_state_t        state;
    logic [2:0]        prev;
    logic              seq_error_q;
    logic [WRAP_W-1:0] wrap_q;

    // The first valid code only seeds prev; afterwards every valid code must be prev+1 mod 8.
    always_ff @(posedge clockpulse) begin
        if (clear) begin
            state       <= EMPTY;
            prev        <= 3'd0;
            seq_error_q <= 1'b0;
            wrap_q      <= '0;
        end else if (valid_accept) begin
            prev <= code_next;
            if (state == EMPTY) begin
                state <= LOCKED;
            end else begin
                if (code_next != prev + 3'd1) begin
                    seq_error_q <= 1'b1;
                end
                if ((prev == 3'd7) && (code_next == 3'd0)) begin
                    wrap_q <= wrap_q + WRAP_W'(1);
                end
            end
        end
    end

    assign bus.seq_error  = seq_error_q;
    assign bus.wrap_count = wrap_q;
`else
    assign bus.seq_error  = 1'b0;
    assign bus.wrap_count = '0;
`endif
endmodule

// File: tb/tb_onehot_encoder_8to3.sv
// Self-checking bench for onehot_encoder_8to3: directed scenarios plus randomized patterns,
// compared every cycle against a sliding-window behavioural model.
module tb_onehot_encoder_8to3;
    localparam int STABLE_CYCLES = 3;
    localparam int WRAP_W        = 4;
`ifdef ENCODER_SEQCHECK_EN
    localparam int SEQ_ON = 1;
`else
    localparam int SEQ_ON = 0;
`endif

    logic clockpulse = 1'b0;
    logic clear      = 1'b1;
    int   checks     = 0;
    int   errors     = 0;
    int   step_count = 0;

    onehot_encoder_8to3_if #(.WRAP_W(WRAP_W)) bus ();

    onehot_encoder_8to3 #(
        .STABLE_CYCLES(STABLE_CYCLES),
        .WRAP_W       (WRAP_W)
    ) dut (
        .clockpulse(clockpulse),
        .clear     (clear),
        .bus       (bus)
    );

    always #5 clockpulse = ~clockpulse;

    // Model state: last STABLE_CYCLES samples since clear, and the expected outputs.
    logic [7:0] hist[$];
    logic [7:0] m_acc    = 8'd0;
    int         m_code   = 0;
    bit         m_valid  = 1'b0;
    bit         m_multi  = 1'b0;
    bit         m_step   = 1'b0;
    bit         m_seq    = 1'b0;
    int         m_wrap   = 0;
    bit         m_locked = 1'b0;
    int         m_prev   = 0;
    bit         check_en = 1'b0;

    function automatic int highest_bit(input logic [7:0] p);
        for (int i = 7; i >= 0; i--) begin
            if (p[i]) return i;
        end
        return -1;
    endfunction

    function automatic int popcount(input logic [7:0] p);
        int n = 0;
        for (int i = 0; i < 8; i++) begin
            if (p[i]) n++;
        end
        return n;
    endfunction

    function automatic bit window_stable();
        if (hist.size() != STABLE_CYCLES) return 1'b0;
        foreach (hist[i]) begin
            if (hist[i] != hist[0]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, actual, expected);
        end
    endtask

    always @(posedge clockpulse) begin
        int new_code;
        if (clear) begin
            hist.delete();
            m_acc    = 8'd0;
            m_code   = 0;
            m_valid  = 1'b0;
            m_multi  = 1'b0;
            m_step   = 1'b0;
            m_seq    = 1'b0;
            m_wrap   = 0;
            m_locked = 1'b0;
            m_prev   = 0;
            check_en = 1'b1;
        end else begin
            m_step = 1'b0;
            hist.push_back(bus.signal_i);
            if (hist.size() > STABLE_CYCLES) void'(hist.pop_front());
            if (window_stable() && (hist[0] != m_acc)) begin
                m_acc = hist[0];
                if (m_acc == 8'd0) begin
                    m_valid = 1'b0;
                    m_multi = 1'b0;
                end else begin
                    new_code = highest_bit(m_acc);
                    m_valid  = 1'b1;
                    m_multi  = (popcount(m_acc) > 1);
                    m_step   = 1'b1;
                    m_code   = new_code;
`ifdef ENCODER_SEQCHECK_EN
                    if (m_locked) begin
                        if (new_code != (m_prev + 1) % 8) m_seq = 1'b1;
                        if (m_prev == 7 && new_code == 0) m_wrap = (m_wrap + 1) % (1 << WRAP_W);
                    end
`endif
                    m_locked = 1'b1;
                    m_prev   = new_code;
                end
            end
        end
    end

    always @(negedge clockpulse) begin
        if (check_en) begin
            checkOutput("model_signal_o", bus.signal_o, m_code);
            checkOutput("model_valid", bus.valid, m_valid);
            checkOutput("model_multi_hot", bus.multi_hot, m_multi);
            checkOutput("model_step", bus.step, m_step);
            checkOutput("model_seq_error", bus.seq_error, m_seq);
            checkOutput("model_wrap_count", bus.wrap_count, m_wrap);
            if (bus.step === 1'b1) step_count++;
        end
    end

    task automatic applyStimulus(input logic [7:0] p, input int n);
        bus.signal_i = p;
        repeat (n) @(posedge clockpulse);
        #1;
    endtask

    task automatic resetDut(input int n);
        clear = 1'b1;
        repeat (n) @(posedge clockpulse);
        #1;
        clear = 1'b0;
    endtask

    initial begin
        int s0;
        int last_idx;
        int hold;
        int kind;
        logic [7:0] p;

        bus.signal_i = 8'd0;
        resetDut(2);
        checkOutput("reset_signal_o", bus.signal_o, 0);
        checkOutput("reset_valid", bus.valid, 0);
        checkOutput("reset_step", bus.step, 0);
        checkOutput("reset_wrap", bus.wrap_count, 0);

        s0 = step_count;
        applyStimulus(8'h04, 2);
        checkOutput("hold04_not_yet", bus.valid, 0);
        applyStimulus(8'h04, 1);
        checkOutput("hold04_code", bus.signal_o, 2);
        checkOutput("hold04_valid", bus.valid, 1);
        checkOutput("hold04_step", bus.step, 1);
        applyStimulus(8'h04, 2);
        checkOutput("hold04_single_step", step_count - s0, 1);

        resetDut(1);
        s0 = step_count;
        for (int i = 0; i < 9; i++) begin
            applyStimulus(8'h01 << (i % 8), 4);
        end
        checkOutput("walk_steps", step_count - s0, 9);
        checkOutput("walk_code", bus.signal_o, 0);
        checkOutput("walk_seq_error", bus.seq_error, 0);
        checkOutput("walk_wrap", bus.wrap_count, SEQ_ON);

        resetDut(1);
        s0 = step_count;
        applyStimulus(8'h08, 3);
        applyStimulus(8'h10, 2);
        applyStimulus(8'h08, 3);
        checkOutput("glitch_code", bus.signal_o, 3);
        checkOutput("glitch_steps", step_count - s0, 1);
        applyStimulus(8'h10, 3);
        checkOutput("after_glitch_code", bus.signal_o, 4);

        resetDut(1);
        applyStimulus(8'h02, 3);
        applyStimulus(8'h10, 3);
        checkOutput("skip_seq_error", bus.seq_error, SEQ_ON);
        applyStimulus(8'h20, 3);
        applyStimulus(8'h40, 3);
        checkOutput("sticky_seq_error", bus.seq_error, SEQ_ON);

        applyStimulus(8'h28, 3);
        checkOutput("multi_code", bus.signal_o, 5);
        checkOutput("multi_valid", bus.valid, 1);
        checkOutput("multi_flag", bus.multi_hot, 1);
        applyStimulus(8'h00, 3);
        checkOutput("zero_valid", bus.valid, 0);
        checkOutput("zero_code_held", bus.signal_o, 5);
        checkOutput("zero_multi", bus.multi_hot, 0);
        checkOutput("zero_step", bus.step, 0);

        applyStimulus(8'h40, 2);
        resetDut(1);
        checkOutput("midclear_code", bus.signal_o, 0);
        checkOutput("midclear_valid", bus.valid, 0);
        checkOutput("midclear_seq", bus.seq_error, 0);
        applyStimulus(8'h40, 2);
        checkOutput("reaccept_early", bus.step, 0);
        applyStimulus(8'h40, 1);
        checkOutput("reaccept_step", bus.step, 1);
        checkOutput("reaccept_code", bus.signal_o, 6);

        last_idx = 6;
        for (int n = 0; n < 250; n++) begin
            kind = $urandom_range(0, 9);
            hold = $urandom_range(1, 5);
            if (kind <= 5) begin
                last_idx = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : (last_idx + 1) % 8;
                p = 8'h01 << last_idx;
            end else if (kind == 6) begin
                p = 8'h00;
            end else if (kind == 7) begin
                p = 8'($urandom);
            end else begin
                p = bus.signal_i;
            end
            if (kind == 8) begin
                resetDut(1);
            end else begin
                applyStimulus(p, hold);
            end
        end

        @(negedge clockpulse);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
